// File: rtl/stack_engine_pkg.sv
// stack_engine_pkg: opcodes, error codes and RUN/HALT encoding shared by the stack engine.
package stack_engine_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_OVER = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;
    localparam logic [1:0] ERR_ILL  = 2'd3;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/stack_engine_check.sv
// stack_engine_check: combinational op legality and error code from (op, count, full).
// Opcodes 6/7 are illegal unless STACK_ENGINE_ALU_EN is defined.
module stack_engine_check
    import stack_engine_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic [2:0]    op,
    input  logic [CW-1:0] count,
    input  logic          full,
    output logic          legal,
    output logic [1:0]    code
);

    logic ovf;
    logic unf;
    logic ill;

    always_comb begin
        ovf = (op == OP_PUSH || op == OP_DUP || op == OP_OVER) && full;
        unf = ((op == OP_POP || op == OP_DUP) && count == '0) ||
              ((op == OP_SWAP || op == OP_OVER || op == OP_ADD || op == OP_SUB) && count < CW'(2));
`ifdef STACK_ENGINE_ALU_EN
        ill = 1'b0;
`else
        ill = op == OP_ADD || op == OP_SUB;
`endif
        code  = ill ? ERR_ILL : ovf ? ERR_OVF : unf ? ERR_UNF : ERR_NONE;
        legal = code == ERR_NONE;
    end

endmodule

// File: rtl/stack_engine.sv
// stack_engine: parametrised shift-register operand stack with error halt and clear handshake.
// Define STACK_ENGINE_ALU_EN to build ADD/SUB; otherwise opcodes 6/7 raise an illegal-op error.
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           din,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t                        state, state_nxt;
    logic [DEPTH-1:0][WIDTH-1:0]   stk, stk_nxt;
    logic [CW-1:0]                 count_nxt;
    logic                          err_nxt;
    logic [1:0]                    code_nxt;
    logic                          legal;
    logic [1:0]                    chk_code;
    logic                          accept;
    logic                          do_push;
    logic                          do_pop;
    logic [WIDTH-1:0]              push_v;

    stack_engine_check #(.DEPTH(DEPTH), .CW(CW)) u_check (
        .op    (op),
        .count (count),
        .full  (full),
        .legal (legal),
        .code  (chk_code)
    );

    assign op_ready = state == ST_RUN;
    assign accept   = op_valid && op_ready;
    assign tos      = stk[0];
    assign nos      = stk[1];
    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign do_push  = op == OP_PUSH || op == OP_DUP || op == OP_OVER;
    assign push_v   = op == OP_PUSH ? din : op == OP_DUP ? stk[0] : stk[1];
`ifdef STACK_ENGINE_ALU_EN
    logic [WIDTH-1:0] alu_v;
    assign do_pop = op == OP_POP || op == OP_ADD || op == OP_SUB;
    assign alu_v  = op == OP_ADD ? stk[1] + stk[0] : stk[1] - stk[0];
`else
    assign do_pop = op == OP_POP;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            stk      <= '0;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nxt;
            stk      <= stk_nxt;
            count    <= count_nxt;
            err      <= err_nxt;
            err_code <= code_nxt;
        end
    end

    // An erroring op is consumed without touching the stack; vacated slots shift in zero.
    always_comb begin
        state_nxt = state;
        stk_nxt   = stk;
        count_nxt = count;
        err_nxt   = err;
        code_nxt  = err_code;
        if (state == ST_HALT) begin
            if (clr_err) begin
                state_nxt = ST_RUN;
                err_nxt   = 1'b0;
                code_nxt  = ERR_NONE;
            end
        end else if (accept && !legal) begin
            state_nxt = ST_HALT;
            err_nxt   = 1'b1;
            code_nxt  = chk_code;
        end else if (accept) begin
            if (do_push) begin
                stk_nxt   = {stk[DEPTH-2:0], push_v};
                count_nxt = count + CW'(1);
            end else if (do_pop) begin
                stk_nxt   = {WIDTH'(0), stk[DEPTH-1:1]};
`ifdef STACK_ENGINE_ALU_EN
                stk_nxt[0] = op == OP_POP ? stk[1] : alu_v;
`endif
                count_nxt = count - CW'(1);
            end else if (op == OP_SWAP) begin
                stk_nxt[0] = stk[1];
                stk_nxt[1] = stk[0];
            end
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: queue-based reference model checked every cycle, plus directed literal checks.
module tb_stack_engine;

    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic         clr_err;
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         err;
    logic [1:0]   err_code;

    int n_checks = 0;
    int n_fail   = 0;

    stack_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .din      (din),
        .clr_err  (clr_err),
        .tos      (tos),
        .nos      (nos),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: q[0] is the top of stack.
    int q[$];
    bit m_halt;
    int m_code;
    bit check_en = 0;

    always @(posedge clk) begin
        int c;
        int a;
        int b;
        if (rst) begin
            q.delete();
            m_halt   = 0;
            m_code   = 0;
            check_en = 1;
        end else if (m_halt) begin
            if (clr_err) begin
                m_halt = 0;
                m_code = 0;
            end
        end else if (op_valid) begin
            c = 0;
            case (op)
                3'd1: c = q.size() == D ? 1 : 0;
                3'd2: c = q.size() == 0 ? 2 : 0;
                3'd3: c = q.size() == D ? 1 : q.size() == 0 ? 2 : 0;
                3'd4: c = q.size() < 2 ? 2 : 0;
                3'd5: c = q.size() == D ? 1 : q.size() < 2 ? 2 : 0;
`ifdef STACK_ENGINE_ALU_EN
                3'd6, 3'd7: c = q.size() < 2 ? 2 : 0;
`else
                3'd6, 3'd7: c = 3;
`endif
                default: c = 0;
            endcase
            if (c != 0) begin
                m_halt = 1;
                m_code = c;
            end else begin
                case (op)
                    3'd1: q.push_front(int'(din));
                    3'd2: void'(q.pop_front());
                    3'd3: q.push_front(q[0]);
                    3'd4: begin a = q[0]; q[0] = q[1]; q[1] = a; end
                    3'd5: q.push_front(q[1]);
                    3'd6: begin a = q.pop_front(); b = q.pop_front(); q.push_front((b + a) % 16); end
                    3'd7: begin a = q.pop_front(); b = q.pop_front(); q.push_front((b - a + 16) % 16); end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (check_en) begin
            check("m_tos",   tos,      q.size() > 0 ? q[0] : 0);
            check("m_nos",   nos,      q.size() > 1 ? q[1] : 0);
            check("m_count", count,    q.size());
            check("m_full",  full,     q.size() == D);
            check("m_empty", empty,    q.size() == 0);
            check("m_err",   err,      m_code != 0);
            check("m_code",  err_code, m_code);
            check("m_ready", op_ready, !m_halt);
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] d);
        op_valid = 1'b1;
        op       = o;
        din      = d;
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_clear();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = 3'd0; din = '0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", op_ready, 1);

        // PUSH 3, PUSH 5, ADD
        do_op(3'd1, 4'd3); do_op(3'd1, 4'd5); do_op(3'd6, 4'd0);
`ifdef STACK_ENGINE_ALU_EN
        check("add_tos", tos, 8); check("add_nos", nos, 0); check("add_count", count, 1);
`else
        check("add_ill", err_code, 3); check("add_tos", tos, 5); check("add_count", count, 2);
        do_clear();
`endif
        do_reset();

        // PUSH 2, PUSH 5, SUB wraps to 0xD
        do_op(3'd1, 4'd2); do_op(3'd1, 4'd5); do_op(3'd7, 4'd0);
`ifdef STACK_ENGINE_ALU_EN
        check("sub_tos", tos, 13); check("sub_count", count, 1);
`else
        check("sub_ill", err_code, 3); check("sub_tos", tos, 5);
        do_clear();
`endif
        do_reset();

        // Fill, then overflow
        for (int i = 1; i <= D; i++) do_op(3'd1, W'(i));
        check("fill_full", full, 1);
        do_op(3'd1, 4'd9);
        check("ovf_code", err_code, 1);
        check("ovf_ready", op_ready, 0);
        check("ovf_tos", tos, 8);
        check("ovf_nos", nos, 7);
        check("ovf_count", count, 8);
        do_clear();
        check("clr_ready", op_ready, 1);
        do_reset();

        // Underflow, held PUSH in HALT, clear with op in same cycle
        do_op(3'd2, 4'd0);
        check("unf_code", err_code, 2);
        op_valid = 1'b1; op = 3'd1; din = 4'd7;
        repeat (3) @(negedge clk);
        check("halt_count", count, 0);
        check("halt_ready", op_ready, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_same_count", count, 0);
        check("clr_err0", err, 0);
        check("clr_ready1", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        check("after_clr_count", count, 1);
        check("after_clr_tos", tos, 7);
        do_reset();

        // PUSH 1, PUSH 2, SWAP, OVER, then DUP, DROP, DROP
        do_op(3'd1, 4'd1); do_op(3'd1, 4'd2); do_op(3'd4, 4'd0); do_op(3'd5, 4'd0);
        check("over_tos", tos, 2); check("over_nos", nos, 1); check("over_count", count, 3);
        do_op(3'd3, 4'd0); do_op(3'd2, 4'd0); do_op(3'd2, 4'd0);
        check("drop_tos", tos, 1); check("drop_count", count, 2);
        do_reset();

        // Reset while halted with a non-empty stack
        for (int i = 1; i <= 4; i++) do_op(3'd1, W'(i + 10));
`ifdef STACK_ENGINE_ALU_EN
        for (int i = 5; i <= D + 1; i++) do_op(3'd1, W'(i));
`else
        do_op(3'd6, 4'd0);
        check("halt4_count", count, 4);
`endif
        check("halt_state", op_ready, 0);
        do_reset();
        check("rst2_tos", tos, 0);
        check("rst2_nos", nos, 0);
        check("rst2_count", count, 0);
        check("rst2_err", err, 0);
        check("rst2_code", err_code, 0);
        check("rst2_ready", op_ready, 1);
        check("rst2_empty", empty, 1);
        check("rst2_full", full, 0);
        do_op(3'd0, 4'd0);
        check("nop_count", count, 0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
